line_drawer: RTL and testbench



---
 rtl/line_drawer.sv | 173 +++++++++++++++++
 tb/tb_line_drawer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/line_drawer.sv
// Bresenham line rasteriser: one segment per command, one pixel per output handshake.
// Optional macro LINE_DRAWER_CLIP_EN: off-screen pixels are stepped through without being emitted.
module line_drawer #(
    parameter  int HOR_ACTIVE_PIXELS = 640,
    parameter  int VER_ACTIVE_PIXELS = 480,
    localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y2,
    input  logic               start,
    output logic               ready,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               pixel_valid,
    input  logic               pixel_ready
);
    localparam int W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
`ifdef LINE_DRAWER_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif
    localparam logic [W-1:0]       H_LIM = W'(HOR_ACTIVE_PIXELS);
    localparam logic [W-1:0]       V_LIM = W'(VER_ACTIVE_PIXELS);
    localparam logic [X_WIDTH-1:0] X_ONE = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0] Y_ONE = Y_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [X_WIDTH-1:0]    cur_x_q, cur_x_d, end_x_q, end_x_d;
    logic [Y_WIDTH-1:0]    cur_y_q, cur_y_d, end_y_q, end_y_d;
    logic signed [W-1:0]   dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                  sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic                  valid_q, valid_d, ready_q, ready_d;

    logic signed [W-1:0]   cx_s, cy_s, ex_s, ey_s, adx_s, ady_s, e2_s, err_nx_s;
    logic [X_WIDTH-1:0]    nx_x_s;
    logic [Y_WIDTH-1:0]    nx_y_s;
    logic                  step_x_s, step_y_s, advance_s, at_end_s;

    function automatic logic on_screen(input logic [X_WIDTH-1:0] x, input logic [Y_WIDTH-1:0] y);
        on_screen = !CLIP_EN ||
                    (({{(W-X_WIDTH){1'b0}}, x} < H_LIM) && ({{(W-Y_WIDTH){1'b0}}, y} < V_LIM));
    endfunction

    // Next-state, Bresenham step and handshake logic
    always_comb begin
        state_d  = state_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        end_x_d  = end_x_q;
        end_y_d  = end_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        valid_d  = valid_q;
        ready_d  = ready_q;

        cx_s  = $signed({{(W-X_WIDTH){1'b0}}, cur_x_q});
        cy_s  = $signed({{(W-Y_WIDTH){1'b0}}, cur_y_q});
        ex_s  = $signed({{(W-X_WIDTH){1'b0}}, end_x_q});
        ey_s  = $signed({{(W-Y_WIDTH){1'b0}}, end_y_q});
        adx_s = (ex_s > cx_s) ? (ex_s - cx_s) : (cx_s - ex_s);
        ady_s = (ey_s > cy_s) ? (ey_s - cy_s) : (cy_s - ey_s);

        // Both step decisions use the error term from before this step.
        e2_s      = err_q <<< 1;
        step_x_s  = (e2_s >= dy_q);
        step_y_s  = (e2_s <= dx_q);
        err_nx_s  = err_q + (step_x_s ? dy_q : {W{1'b0}}) + (step_y_s ? dx_q : {W{1'b0}});
        nx_x_s    = step_x_s ? (sx_neg_q ? (cur_x_q - X_ONE) : (cur_x_q + X_ONE)) : cur_x_q;
        nx_y_s    = step_y_s ? (sy_neg_q ? (cur_y_q - Y_ONE) : (cur_y_q + Y_ONE)) : cur_y_q;
        advance_s = !valid_q || pixel_ready;
        at_end_s  = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                valid_d = 1'b0;
                if (start) begin
                    cur_x_d = x1;
                    cur_y_d = y1;
                    end_x_d = x2;
                    end_y_d = y2;
                    ready_d = 1'b0;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                dx_d     = adx_s;
                dy_d     = -ady_s;
                err_d    = adx_s - ady_s;
                sx_neg_d = !(ex_s > cx_s);
                sy_neg_d = !(ey_s > cy_s);
                valid_d  = on_screen(cur_x_q, cur_y_q);
                state_d  = DRAW;
            end
            DRAW: begin
                if (advance_s) begin
                    if (at_end_s) begin
                        valid_d = 1'b0;
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cur_x_d = nx_x_s;
                        cur_y_d = nx_y_s;
                        err_d   = err_nx_s;
                        valid_d = on_screen(nx_x_s, nx_y_s);
                        state_d = DRAW;
                    end
                end else begin
                    state_d = DRAW;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cur_x_q  <= {X_WIDTH{1'b0}};
            cur_y_q  <= {Y_WIDTH{1'b0}};
            end_x_q  <= {X_WIDTH{1'b0}};
            end_y_q  <= {Y_WIDTH{1'b0}};
            dx_q     <= {W{1'b0}};
            dy_q     <= {W{1'b0}};
            err_q    <= {W{1'b0}};
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            end_x_q  <= end_x_d;
            end_y_q  <= end_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
        end
    end

    assign ready       = ready_q;
    assign pixel_valid = valid_q;
    assign pixel_x     = cur_x_q;
    assign pixel_y     = cur_y_q;

endmodule

// File: tb/tb_line_drawer.sv
// Directed bench for line_drawer: hand-computed pixel sequences, cycle timing, stalls, clip, reset.
module tb_line_drawer;
    localparam int XW = 10;
    localparam int YW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pixel_ready = 1'b0;
    logic [XW-1:0] x1 = '0, x2 = '0, pixel_x;
    logic [YW-1:0] y1 = '0, y2 = '0, pixel_y;
    logic          ready, pixel_valid;

    int n_cmp = 0;
    int n_err = 0;
    int qx[$];
    int qy[$];

    always #5 clk = ~clk;

    line_drawer dut (
        .clk(clk), .rst_n(rst_n),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .start(start), .ready(ready),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one command; cycle 0 is the accept cycle. Expected pixels come from qx/qy.
    task automatic run_line(input int ax1, input int ay1, input int ax2, input int ay2,
                            input bit alt, input int rdy_cyc);
        int c, idx, extra, first_v, hx, hy;
        bit stalled, pr;
        x1 = XW'(ax1); y1 = YW'(ay1); x2 = XW'(ax2); y2 = YW'(ay2);
        start = 1'b1;
        pixel_ready = 1'b1;
        chk("accept_ready", 32'(ready), 32'd1);
        tick();
        start = 1'b0;
        c = 1;
        chk("setup_ready", 32'(ready), 32'd0);
        chk("setup_valid", 32'(pixel_valid), 32'd0);
        tick();
        c = 2; idx = 0; stalled = 1'b0; first_v = -1; hx = 0; hy = 0;
        while (idx < qx.size() && c < 300) begin
            pr = alt ? c[0] : 1'b1;
            pixel_ready = pr;
            if (alt && c == 4) begin
                start = 1'b1;
                x1 = XW'(100); y1 = YW'(100); x2 = XW'(101); y2 = YW'(101);
                chk("busy_ready", 32'(ready), 32'd0);
            end else begin
                start = 1'b0;
            end
            if (pixel_valid) begin
                if (first_v < 0) first_v = c;
                if (stalled) begin
                    chk("stall_x", 32'(pixel_x), 32'(hx));
                    chk("stall_y", 32'(pixel_y), 32'(hy));
                end
                if (pr) begin
                    chk("pix_x", 32'(pixel_x), 32'(qx[idx]));
                    chk("pix_y", 32'(pixel_y), 32'(qy[idx]));
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hx = int'(pixel_x);
                    hy = int'(pixel_y);
                end
            end
            tick();
            c++;
        end
        start = 1'b0;
        chk("pixel_count", 32'(idx), 32'(qx.size()));
        extra = 0;
        while (!ready && c < 300) begin
            if (pixel_valid) extra++;
            tick();
            c++;
        end
        chk("end_ready", 32'(ready), 32'd1);
        chk("end_valid", 32'(pixel_valid), 32'd0);
        chk("extra_pixels", 32'(extra), 32'd0);
        if (rdy_cyc >= 0) chk("ready_cycle", 32'(c), 32'(rdy_cyc));
        if (!alt) chk("first_valid_cycle", 32'(first_v), 32'd2);
        pixel_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_valid", 32'(pixel_valid), 32'd0);
        chk("rst_px", 32'(pixel_x), 32'd0);
        chk("rst_py", 32'(pixel_y), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        qx = '{0, 1, 2, 3}; qy = '{0, 0, 0, 0};
        run_line(0, 0, 3, 0, 1'b0, 6);

        qx = '{5}; qy = '{5};
        run_line(5, 5, 5, 5, 1'b0, 3);

        qx = '{2, 1, 1, 0, 0}; qy = '{4, 3, 2, 1, 0};
        run_line(2, 4, 0, 0, 1'b0, 7);

        qx = '{10, 11, 12, 13}; qy = '{10, 11, 11, 12};
        run_line(10, 10, 13, 12, 1'b1, -1);

        // Same segment without stalls must give the identical sequence.
        run_line(10, 10, 13, 12, 1'b0, 6);

        qx = {}; qy = {};
`ifdef LINE_DRAWER_CLIP_EN
        for (int i = 636; i < 640; i++) begin qx.push_back(i); qy.push_back(0); end
`else
        for (int i = 636; i < 644; i++) begin qx.push_back(i); qy.push_back(0); end
`endif
        run_line(636, 0, 643, 0, 1'b0, 10);

        // Abort mid-line with an asynchronous reset on the second pixel.
        x1 = XW'(0); y1 = YW'(0); x2 = XW'(9); y2 = YW'(0);
        start = 1'b1;
        pixel_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_valid", 32'(pixel_valid), 32'd1);
        chk("pre_rst_px", 32'(pixel_x), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(pixel_valid), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_px", 32'(pixel_x), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", 32'(pixel_valid), 32'd0);
        end

        qx = '{3, 3}; qy = '{3, 4};
        run_line(3, 3, 3, 4, 1'b0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
